// File: rtl/nsd_pkg.sv
// Shared severity encodings and the epoch match-count classifier used by every
// nerve-sample channel of the nervous shock monitor.
package nsd_pkg;

    localparam logic [1:0] LVL_NORMAL = 2'd0;
    localparam logic [1:0] LVL_MILD   = 2'd1;
    localparam logic [1:0] LVL_SEVERE = 2'd2;
    localparam logic [1:0] LVL_CRIT   = 2'd3;

    function automatic logic [1:0] classify(
        input int cnt,
        input int thr_mild,
        input int thr_severe,
        input int thr_crit
    );
        logic [1:0] lvl;
        lvl = LVL_NORMAL;
        if (cnt >= thr_crit) begin
            lvl = LVL_CRIT;
        end else if (cnt >= thr_severe) begin
            lvl = LVL_SEVERE;
        end else if (cnt >= thr_mild) begin
            lvl = LVL_MILD;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/nsd_channel.sv
// One sensor channel: overlapping pattern detector on the accepted sample stream,
// saturating per-epoch match counter, severity register and sticky critical alarm.
module nsd_channel
    import nsd_pkg::*;
#(
    parameter int                 PAT_LEN    = 3,
    parameter logic [PAT_LEN-1:0] PATTERN    = 3'b100,
    parameter int                 THR_MILD   = 1,
    parameter int                 THR_SEVERE = 3,
    parameter int                 THR_CRIT   = 5,
    parameter int                 CNT_W      = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sample_valid,
    input  logic       sample_in,
    input  logic       epoch_end,
    input  logic       clear_alarm,
    output logic [1:0] level,
    output logic       alarm
);

    localparam int FILL_W = $clog2(PAT_LEN);

    // Only the PAT_LEN-1 most recent samples are kept; the current sample completes the window.
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         level_q, level_d;
    logic               alarm_q, alarm_d;

    logic [PAT_LEN-1:0] window;
    logic               fill_full;
    logic               match;
    logic [CNT_W-1:0]   cnt_plus;
    logic [1:0]         level_new;

    always_comb begin
        window    = {hist_q, sample_in};
        // fill saturates at PAT_LEN-1: with the current sample that makes a full window
        fill_full = (fill_q == FILL_W'(PAT_LEN - 1));
        match     = sample_valid && fill_full && (window == PATTERN);

        cnt_plus = cnt_q;
        if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_plus = cnt_q + CNT_W'(1);
        end
        level_new = classify(int'(cnt_plus), THR_MILD, THR_SEVERE, THR_CRIT);

        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sample_valid) begin
            hist_d = window[PAT_LEN-2:0];
            if (!fill_full) begin
                fill_d = fill_q + FILL_W'(1);
            end
            if (epoch_end) begin
                cnt_d   = '0;
                level_d = level_new;
            end else begin
                cnt_d = cnt_plus;
            end
        end

        // A new critical classification wins over a concurrent clear.
        alarm_d = (alarm_q && !clear_alarm) || (epoch_end && (level_new == LVL_CRIT));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            level_q <= LVL_NORMAL;
            alarm_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            alarm_q <= alarm_d;
        end
    end

    assign level = level_q;
    assign alarm = alarm_q;

endmodule

// File: rtl/nervous_shock_monitor.sv
// Multi-channel nervous shock monitor: shared epoch counter over accepted samples,
// epoch_done strobe, and one nsd_channel per sensor channel.
module nervous_shock_monitor
    import nsd_pkg::*;
#(
    parameter int                 NUM_CH     = 4,
    parameter int                 PAT_LEN    = 3,
    parameter logic [PAT_LEN-1:0] PATTERN    = 3'b100,
    parameter int                 EPOCH_LEN  = 16,
    parameter int                 THR_MILD   = 1,
    parameter int                 THR_SEVERE = 3,
    parameter int                 THR_CRIT   = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [NUM_CH-1:0]     inputdata,
    input  logic                  clear_alarm,
    output logic [2*NUM_CH-1:0]   nervous_abnormality,
    output logic                  epoch_done,
    output logic [NUM_CH-1:0]     alarm
);

    localparam int CNT_W = $clog2(EPOCH_LEN + 1);

    logic [CNT_W-1:0] epoch_q, epoch_d;
    logic             epoch_done_q, epoch_done_d;
    logic             epoch_end;

    always_comb begin
        epoch_end = sample_valid && (epoch_q == CNT_W'(EPOCH_LEN - 1));

        epoch_d = epoch_q;
        if (sample_valid) begin
            epoch_d = epoch_end ? '0 : epoch_q + CNT_W'(1);
        end
        epoch_done_d = epoch_end;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            epoch_q      <= '0;
            epoch_done_q <= 1'b0;
        end else begin
            epoch_q      <= epoch_d;
            epoch_done_q <= epoch_done_d;
        end
    end

    assign epoch_done = epoch_done_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            nsd_channel #(
                .PAT_LEN    (PAT_LEN),
                .PATTERN    (PATTERN),
                .THR_MILD   (THR_MILD),
                .THR_SEVERE (THR_SEVERE),
                .THR_CRIT   (THR_CRIT),
                .CNT_W      (CNT_W)
            ) u_ch (
                .clock        (clock),
                .reset_n      (reset_n),
                .sample_valid (sample_valid),
                .sample_in    (inputdata[gi]),
                .epoch_end    (epoch_end),
                .clear_alarm  (clear_alarm),
                .level        (nervous_abnormality[2*gi +: 2]),
                .alarm        (alarm[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_nervous_shock_monitor.sv
// Vector-table bench for nervous_shock_monitor with a queue scoreboard of expected outputs.
module tb_nervous_shock_monitor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       sample_valid = 1'b0;
    logic [3:0] inputdata = '0;
    logic       clear_alarm = 1'b0;
    logic [7:0] nervous_abnormality;
    logic       epoch_done;
    logic [3:0] alarm;

    nervous_shock_monitor dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .sample_valid        (sample_valid),
        .inputdata           (inputdata),
        .clear_alarm         (clear_alarm),
        .nervous_abnormality (nervous_abnormality),
        .epoch_done          (epoch_done),
        .alarm               (alarm)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       valid;
        logic [3:0] data;
        logic       clear;
        logic       exp_done;
        logic [7:0] exp_lvl;
        logic [3:0] exp_alarm;
        int         tag;
    } vec_t;

    typedef struct {
        logic       done;
        logic [7:0] lvl;
        logic [3:0] alm;
        int         tag;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] d, input logic c,
                       input logic done, input logic [7:0] lvl, input logic [3:0] alm,
                       input int tag);
        vec_t r;
        r.valid = v; r.data = d; r.clear = c;
        r.exp_done = done; r.exp_lvl = lvl; r.exp_alarm = alm; r.tag = tag;
        vecs.push_back(r);
    endtask

    task automatic run_vecs();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            sample_valid = vecs[i].valid;
            inputdata    = vecs[i].data;
            clear_alarm  = vecs[i].clear;
            e.done = vecs[i].exp_done; e.lvl = vecs[i].exp_lvl;
            e.alm = vecs[i].exp_alarm; e.tag = vecs[i].tag; e.idx = i;
            exp_q.push_back(e);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            $display("test %0d vec %0d: valid=%b data=%h clr=%b -> lvl=%h done=%b alarm=%h",
                     e.tag, e.idx, sample_valid, inputdata, clear_alarm,
                     nervous_abnormality, epoch_done, alarm);
            check($sformatf("t%0d v%0d nervous_abnormality", e.tag, e.idx),
                  32'(nervous_abnormality), 32'(e.lvl));
            check($sformatf("t%0d v%0d epoch_done", e.tag, e.idx),
                  32'(epoch_done), 32'(e.done));
            check($sformatf("t%0d v%0d alarm", e.tag, e.idx),
                  32'(alarm), 32'(e.alm));
        end
        vecs.delete();
        @(negedge clock);
        sample_valid = 1'b0;
        inputdata    = '0;
        clear_alarm  = 1'b0;
    endtask

    // Assert reset between clock edges and confirm outputs clear without a clock edge.
    task automatic hard_reset(input int tag);
        @(negedge clock);
        sample_valid = 1'b0;
        inputdata    = '0;
        clear_alarm  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        $display("test %0d reset: lvl=%h done=%b alarm=%h", tag, nervous_abnormality, epoch_done, alarm);
        check($sformatf("t%0d reset nervous_abnormality", tag), 32'(nervous_abnormality), 32'h0);
        check($sformatf("t%0d reset epoch_done", tag), 32'(epoch_done), 32'h0);
        check($sformatf("t%0d reset alarm", tag), 32'(alarm), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b0, b1, b2;

        hard_reset(0);

        // Test 1: ch0 streams 1,0,0,... for 16 samples -> 5 matches -> level 3, alarm set
        for (int k = 0; k < 16; k++) begin
            b0 = (k % 3 == 0);
            add(1'b1, {3'b000, b0}, 1'b0, k == 15, (k == 15) ? 8'h03 : 8'h00,
                (k == 15) ? 4'h1 : 4'h0, 1);
        end
        add(1'b0, 4'h0, 1'b0, 1'b0, 8'h03, 4'h1, 1);
        run_vecs();

        // Test 6: 10 samples into a new epoch, then reset mid-epoch
        for (int k = 0; k < 10; k++) begin
            b0 = (k % 3 == 0);
            add(1'b1, {3'b000, b0}, 1'b0, 1'b0, 8'h03, 4'h1, 6);
        end
        run_vecs();
        hard_reset(6);
        for (int k = 0; k < 16; k++) begin
            b0 = (k == 2);
            add(1'b1, {3'b000, b0}, 1'b0, k == 15, (k == 15) ? 8'h01 : 8'h00, 4'h0, 6);
        end
        add(1'b0, 4'h0, 1'b0, 1'b0, 8'h01, 4'h0, 6);
        run_vecs();

        // Test 2: ch1 one match, ch2 three disjoint matches
        hard_reset(2);
        for (int k = 0; k < 16; k++) begin
            b1 = (k == 0);
            b2 = (k == 0) || (k == 3) || (k == 6);
            add(1'b1, {1'b0, b2, b1, 1'b0}, 1'b0, k == 15, (k == 15) ? 8'h24 : 8'h00, 4'h0, 2);
        end
        add(1'b0, 4'h0, 1'b0, 1'b0, 8'h24, 4'h0, 2);
        run_vecs();

        // Test 3: pattern straddles the epoch boundary, counted in the second epoch
        hard_reset(3);
        for (int k = 0; k < 16; k++) begin
            b0 = (k == 0) || (k == 3) || (k == 14);
            add(1'b1, {3'b000, b0}, 1'b0, k == 15, (k == 15) ? 8'h01 : 8'h00, 4'h0, 3);
        end
        for (int k = 0; k < 16; k++) begin
            add(1'b1, 4'h0, 1'b0, k == 15, 8'h01, 4'h0, 3);
        end
        add(1'b0, 4'h0, 1'b0, 1'b0, 8'h01, 4'h0, 3);
        run_vecs();

        // Test 4: sample_valid toggling; junk data on idle cycles must be ignored
        hard_reset(4);
        for (int k = 0; k < 16; k++) begin
            b0 = (k % 3 == 0);
            add(1'b1, {3'b000, b0}, 1'b0, k == 15, (k == 15) ? 8'h03 : 8'h00,
                (k == 15) ? 4'h1 : 4'h0, 4);
            add(1'b0, 4'hF, 1'b0, 1'b0, (k == 15) ? 8'h03 : 8'h00,
                (k == 15) ? 4'h1 : 4'h0, 4);
        end
        run_vecs();

        // Test 5: clear on the setting cycle loses, clear on the next cycle wins
        hard_reset(5);
        for (int k = 0; k < 16; k++) begin
            b0 = (k % 3 == 0);
            add(1'b1, {3'b000, b0}, k == 15, k == 15, (k == 15) ? 8'h03 : 8'h00,
                (k == 15) ? 4'h1 : 4'h0, 5);
        end
        add(1'b0, 4'h0, 1'b1, 1'b0, 8'h03, 4'h0, 5);
        add(1'b0, 4'h0, 1'b0, 1'b0, 8'h03, 4'h0, 5);
        run_vecs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
